// File: rtl/reset_sequencer.sv
// Board-level reset sequencer: holds NUM_DOMAINS resets, then releases them one at a
// time in index order. A debounced button press or a software request re-arms it.
module reset_sequencer #(
   parameter int CLOCK_HZ        = 48000000,
   parameter int NUM_DOMAINS     = 3,
   parameter int HOLD_CYCLES     = 255,
   parameter int DEBOUNCE_CYCLES = 48000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   btn_n,
   input  logic                   sw_req,
   output logic [NUM_DOMAINS-1:0] domain_rst,
   output logic                   all_released,
   output logic                   busy,
   output logic [2:0]             stage
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DW-1:0] DEB_ONE    = DW'(1);
   localparam logic [3:0]    LAST_STAGE = 4'(NUM_DOMAINS);
   localparam logic [3:0]    STAGE_ONE  = 4'd1;

   if (CLOCK_HZ < 1 || NUM_DOMAINS < 1 || NUM_DOMAINS > 8 ||
       HOLD_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
      $error("reset_sequencer: parameter out of range");
   end

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_t;

   logic [1:0]             sync_q, sync_d;
   logic                   deb_q, deb_d;
   logic [DW-1:0]          deb_cnt_q, deb_cnt_d;
   logic                   press_q, press_d;
   state_t                 state_q, state_d;
   logic [HW-1:0]          hold_q, hold_d;
   logic [3:0]             stage_q, stage_d;
   logic [NUM_DOMAINS-1:0] domain_rst_q, domain_rst_d;
   logic                   all_released_q, all_released_d;
   logic                   trigger;

   // Button: two-flop synchroniser, then a level must persist DEBOUNCE_CYCLES to be accepted
   always_comb begin
      sync_d    = {sync_q[0], btn_n};
      deb_d     = deb_q;
      deb_cnt_d = deb_cnt_q;
      if (sync_q[1] == deb_q) begin
         deb_cnt_d = '0;
      end else if (deb_cnt_q == DEB_LAST) begin
         deb_d     = sync_q[1];
         deb_cnt_d = '0;
      end else begin
         deb_cnt_d = deb_cnt_q + DEB_ONE;
      end
      press_d = deb_q & ~deb_d;
   end

   assign trigger = press_q | sw_req;

   // Trigger wins over a hold expiry in the same cycle
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      stage_d = stage_q;
      if (trigger) begin
         state_d = ST_ASSERT;
         hold_d  = HOLD_LOAD;
         stage_d = '0;
      end else begin
         case (state_q)
            ST_ASSERT, ST_RELEASE: begin
               if (hold_q == '0) begin
                  stage_d = stage_q + STAGE_ONE;
                  hold_d  = HOLD_LOAD;
                  state_d = (stage_d == LAST_STAGE) ? ST_RUN : ST_RELEASE;
               end else begin
                  hold_d = hold_q - HOLD_ONE;
               end
            end
            ST_RUN: begin
            end
            default: begin
               state_d = ST_ASSERT;
               hold_d  = HOLD_LOAD;
               stage_d = '0;
            end
         endcase
      end
      for (int k = 0; k < NUM_DOMAINS; k++) begin
         domain_rst_d[k] = (4'(k) >= stage_d);
      end
      all_released_d = (stage_d == LAST_STAGE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q         <= 2'b11;
         deb_q          <= 1'b1;
         deb_cnt_q      <= '0;
         press_q        <= 1'b0;
         state_q        <= ST_ASSERT;
         hold_q         <= HOLD_LOAD;
         stage_q        <= '0;
         domain_rst_q   <= '1;
         all_released_q <= 1'b0;
      end else begin
         sync_q         <= sync_d;
         deb_q          <= deb_d;
         deb_cnt_q      <= deb_cnt_d;
         press_q        <= press_d;
         state_q        <= state_d;
         hold_q         <= hold_d;
         stage_q        <= stage_d;
         domain_rst_q   <= domain_rst_d;
         all_released_q <= all_released_d;
      end
   end

   assign domain_rst   = domain_rst_q;
   assign all_released = all_released_q;
   assign busy         = ~all_released_q;
   // With eight domains the final count does not fit in three bits; it reads as 7
   assign stage        = (stage_q > 4'd7) ? 3'd7 : stage_q[2:0];

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: constant vector table, directed corner sequences and a
// randomized run checked against a time-since-restart reference model.
module tb_reset_sequencer;

   localparam int N = 3;
   localparam int H = 4;
   localparam int D = 8;

   logic         clk    = 1'b0;
   logic         rst_n  = 1'b0;
   logic         btn_n  = 1'b1;
   logic         sw_req = 1'b0;
   logic [N-1:0] domain_rst;
   logic         all_released;
   logic         busy;
   logic [2:0]   stage;

   int checks   = 0;
   int failures = 0;

   reset_sequencer #(
      .CLOCK_HZ(48000000),
      .NUM_DOMAINS(N),
      .HOLD_CYCLES(H),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .btn_n(btn_n),
      .sw_req(sw_req),
      .domain_rst(domain_rst),
      .all_released(all_released),
      .busy(busy),
      .stage(stage)
   );

   always #5 clk = ~clk;

   // Reference model: edges since the last restart, plus a run-length button filter
   int     m_t;
   bit [1:0] m_hist;
   bit     m_deb;
   int     m_run;
   bit     m_press;

   function automatic void model_reset();
      m_t     = 0;
      m_hist  = 2'b11;
      m_deb   = 1'b1;
      m_run   = 0;
      m_press = 1'b0;
   endfunction

   function automatic void model_edge();
      bit seen;
      bit trig;
      bit fell;
      seen = m_hist[1];
      trig = sw_req | m_press;
      fell = 1'b0;
      if (seen != m_deb) begin
         m_run++;
         if (m_run == D) begin
            m_deb = seen;
            m_run = 0;
            fell  = (seen == 1'b0);
         end
      end else begin
         m_run = 0;
      end
      m_hist  = {m_hist[0], btn_n};
      m_press = fell;
      if (trig) m_t = 0;
      else if (m_t <= N * H) m_t++;
   endfunction

   function automatic int exp_released();
      int r;
      r = m_t / H;
      return (r > N) ? N : r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_out(input string name, input logic [2:0] e_dom, input bit e_all,
                          input logic [2:0] e_stg);
      chk({name, "_dom"},   32'(domain_rst),   32'(e_dom));
      chk({name, "_all"},   32'(all_released), 32'(e_all));
      chk({name, "_busy"},  32'(busy),         32'(!e_all));
      chk({name, "_stage"}, 32'(stage),        32'(e_stg));
   endtask

   task automatic chk_reset(input string name);
      chk_out(name, 3'b111, 1'b0, 3'd0);
   endtask

   task automatic check_model();
      int r;
      logic [2:0] e_dom;
      r = exp_released();
      for (int k = 0; k < N; k++) e_dom[k] = (k >= r);
      chk_out("model", e_dom, (r == N), 3'(r));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_model();
   endtask

   typedef struct {
      int         n;
      bit         sw;
      logic [2:0] dom;
      bit         all;
      logic [2:0] stg;
   } vec_t;

   vec_t tbl[13];

   initial begin
      int restarts;
      logic [2:0] prev;
      int btn_left;

      tbl[0]  = '{0, 1'b0, 3'b111, 1'b0, 3'd0};
      tbl[1]  = '{3, 1'b0, 3'b111, 1'b0, 3'd0};
      tbl[2]  = '{1, 1'b0, 3'b110, 1'b0, 3'd1};
      tbl[3]  = '{3, 1'b0, 3'b110, 1'b0, 3'd1};
      tbl[4]  = '{1, 1'b0, 3'b100, 1'b0, 3'd2};
      tbl[5]  = '{3, 1'b0, 3'b100, 1'b0, 3'd2};
      tbl[6]  = '{1, 1'b0, 3'b000, 1'b1, 3'd3};
      tbl[7]  = '{8, 1'b0, 3'b000, 1'b1, 3'd3};
      tbl[8]  = '{1, 1'b1, 3'b111, 1'b0, 3'd0};
      tbl[9]  = '{3, 1'b0, 3'b111, 1'b0, 3'd0};
      tbl[10] = '{1, 1'b0, 3'b110, 1'b0, 3'd1};
      tbl[11] = '{7, 1'b0, 3'b100, 1'b0, 3'd2};
      tbl[12] = '{1, 1'b0, 3'b000, 1'b1, 3'd3};

      model_reset();
      repeat (3) @(negedge clk);
      chk_reset("por");
      rst_n = 1'b1;

      // Power-up release and a one-cycle software request from RUN
      for (int i = 0; i < 13; i++) begin
         sw_req = tbl[i].sw;
         repeat (tbl[i].n) tick();
         chk_out($sformatf("tbl%0d", i), tbl[i].dom, tbl[i].all, tbl[i].stg);
      end
      sw_req = 1'b0;

      // Short button glitch must be ignored
      btn_n = 1'b0;
      repeat (5) tick();
      btn_n = 1'b1;
      repeat (20) tick();
      chk("glitch_no_restart", 32'(all_released), 32'd1);

      // Held press: exactly one restart, domain_rst all set at B+11
      btn_n    = 1'b0;
      restarts = 0;
      prev     = domain_rst;
      for (int c = 1; c <= 50; c++) begin
         if (c == 21) btn_n = 1'b1;
         tick();
         if (domain_rst == 3'b111 && prev != 3'b111) restarts++;
         prev = domain_rst;
         if (c == 10) chk("btn_b10_dom", 32'(domain_rst), 32'(3'b000));
         if (c == 11) chk("btn_b11_dom", 32'(domain_rst), 32'(3'b111));
      end
      chk("btn_single_restart", 32'(restarts), 32'd1);
      chk("btn_release_run", 32'(all_released), 32'd1);

      // sw_req held ten cycles while stage 1
      sw_req = 1'b1;
      tick();
      sw_req = 1'b0;
      repeat (5) tick();
      chk_out("swhold_before", 3'b110, 1'b0, 3'd1);
      sw_req = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk_out("swhold_during", 3'b111, 1'b0, 3'd0);
      end
      sw_req = 1'b0;
      repeat (3) tick();
      chk_out("swhold_pre", 3'b111, 1'b0, 3'd0);
      tick();
      chk_out("swhold_release", 3'b110, 1'b0, 3'd1);

      // Trigger landing on the same edge as a hold expiry
      repeat (3) tick();
      chk_out("coin_pre", 3'b110, 1'b0, 3'd1);
      sw_req = 1'b1;
      tick();
      sw_req = 1'b0;
      chk_out("coin_edge", 3'b111, 1'b0, 3'd0);
      repeat (3) tick();
      chk_out("coin_hold", 3'b111, 1'b0, 3'd0);
      tick();
      chk_out("coin_release", 3'b110, 1'b0, 3'd1);

      // Asynchronous reset at stage 2, then a full rerun
      repeat (4) tick();
      chk_out("prerst", 3'b100, 1'b0, 3'd2);
      #2 rst_n = 1'b0;
      #1 chk_reset("async_rst");
      model_reset();
      @(posedge clk);
      @(negedge clk);
      chk_reset("held_rst");
      rst_n = 1'b1;
      repeat (4) tick();
      chk_out("rerun_e4", 3'b110, 1'b0, 3'd1);
      repeat (7) tick();
      chk_out("rerun_e11", 3'b100, 1'b0, 3'd2);
      tick();
      chk_out("rerun_e12", 3'b000, 1'b1, 3'd3);

      // Randomized button, software requests and rare reset pulses
      btn_left = 0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 799) == 0) begin
            #1 rst_n = 1'b0;
            #1 chk_reset("rnd_async_rst");
            #1 rst_n = 1'b1;
            model_reset();
         end
         if (btn_left == 0) begin
            btn_n    = ($urandom_range(0, 1) == 1);
            btn_left = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 30) : $urandom_range(1, 10);
         end
         btn_left--;
         sw_req = ($urandom_range(0, 59) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
